// File: rtl/proc_defs.sv
// Shared definitions for the 16-bit Harvard core: opcodes, instruction field
// positions, sequencer state encoding and ALU op codes (opcode - 4).
package proc_defs;

    localparam int OPC_HI      = 31;
    localparam int OPC_LO      = 26;
    localparam int RDST2_HI    = 25;
    localparam int RDST2_LO    = 21;
    localparam int RDST1_HI    = 20;
    localparam int RDST1_LO    = 16;
    localparam int ST_ADDR_HI  = 25;
    localparam int ST_ADDR_LO  = 18;
    localparam int IMM_HI      = 15;
    localparam int RSRC2_HI    = 9;
    localparam int RSRC2_LO    = 5;
    localparam int RSRC1_HI    = 4;
    localparam int ADDR8_HI    = 7;

    localparam logic [5:0] OP_LDI       = 6'd0;
    localparam logic [5:0] OP_MOV       = 6'd1;
    localparam logic [5:0] OP_LD        = 6'd2;
    localparam logic [5:0] OP_ST        = 6'd3;
    localparam logic [5:0] OP_ALU_FIRST = 6'd4;
    localparam logic [5:0] OP_ALU_LAST  = 6'd17;
    localparam logic [5:0] OP_HALT      = 6'd63;

    localparam logic [3:0] ALU_ADD = 4'd9;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM_RD,
        S_ALU_WAIT,
        S_WB2,
        S_WB1,
        S_HALT
    } state_t;

    function automatic logic [3:0] alu_op_of(input logic [5:0] opc);
        return 4'(opc - OP_ALU_FIRST);
    endfunction

endpackage

// File: rtl/instr_fields.sv
// Pure combinational split of a 32-bit instruction word into its fields and
// class bits (ALU op, illegal opcode).
module instr_fields
    import proc_defs::*;
(
    input  logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [4:0]  rdst2,
    output logic [4:0]  rdst1,
    output logic [4:0]  rsrc2,
    output logic [4:0]  rsrc1,
    output logic [15:0] imm16,
    output logic [7:0]  addr8,
    output logic [7:0]  st_addr,
    output logic        is_alu,
    output logic        is_illegal
);

    assign opcode  = ir[OPC_HI:OPC_LO];
    assign rdst2   = ir[RDST2_HI:RDST2_LO];
    assign rdst1   = ir[RDST1_HI:RDST1_LO];
    assign rsrc2   = ir[RSRC2_HI:RSRC2_LO];
    assign rsrc1   = ir[RSRC1_HI:0];
    assign imm16   = ir[IMM_HI:0];
    assign addr8   = ir[ADDR8_HI:0];
    assign st_addr = ir[ST_ADDR_HI:ST_ADDR_LO];

    assign is_alu     = (opcode >= OP_ALU_FIRST) && (opcode <= OP_ALU_LAST);
    assign is_illegal = (opcode > OP_ST) && !is_alu && (opcode != OP_HALT);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/write-back sequencer. Owns PC, IR and the
// only register-file write port and ALU issue of the core.
module instr_sequencer
    import proc_defs::*;
#(
    parameter int PC_W    = 8,
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 5,
    parameter int DMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [REG_AW-1:0]  rf_raddr_a,
    output logic [REG_AW-1:0]  rf_raddr_b,
    input  logic [DATA_W-1:0]  rf_rdata_a,
    input  logic [DATA_W-1:0]  rf_rdata_b,
    output logic               rf_we,
    output logic [REG_AW-1:0]  rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               alu_valid,
    input  logic               alu_ready,
    output logic [3:0]         alu_op,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic               alu_done,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic [DATA_W-1:0]  alu_aux,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic               dmem_we,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output state_t             state_dbg
);

    state_t            state;
    logic [31:0]       ir;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] aux_q;

    logic [5:0]  opcode;
    logic [4:0]  rdst2, rdst1, rsrc2, rsrc1;
    logic [15:0] imm16;
    logic [7:0]  addr8, st_addr;
    logic        is_alu, is_illegal;

    instr_fields u_fields (
        .ir         (ir),
        .opcode     (opcode),
        .rdst2      (rdst2),
        .rdst1      (rdst1),
        .rsrc2      (rsrc2),
        .rsrc1      (rsrc1),
        .imm16      (imm16),
        .addr8      (addr8),
        .st_addr    (st_addr),
        .is_alu     (is_alu),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            res_q   <= '0;
            aux_q   <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc    <= '0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    ir    <= imem_rdata;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_illegal) begin
                        illegal <= 1'b1;
                        halted  <= 1'b1;
                        state   <= S_HALT;
                    end else if (is_alu) begin
                        if (alu_ready) state <= S_ALU_WAIT;
                    end else begin
                        case (opcode)
                            OP_LDI: begin
                                res_q <= DATA_W'(imm16);
                                state <= S_WB2;
                            end
                            OP_MOV: begin
                                res_q <= rf_rdata_a;
                                state <= S_WB2;
                            end
                            OP_LD:  state <= S_MEM_RD;
                            OP_ST: begin
                                pc    <= pc + 1'b1;
                                state <= S_FETCH;
                            end
                            default: begin
                                halted <= 1'b1;
                                state  <= S_HALT;
                            end
                        endcase
                    end
                end
                S_MEM_RD: begin
                    res_q <= dmem_rdata;
                    state <= S_WB2;
                end
                // A done pulse on the handshake cycle is never seen: only this state samples it.
                S_ALU_WAIT: begin
                    if (alu_done) begin
                        res_q <= alu_result;
                        aux_q <= alu_aux;
                        state <= S_WB2;
                    end
                end
                S_WB2: begin
                    if (is_alu) begin
                        state <= S_WB1;
                    end else begin
                        pc    <= pc + 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_WB1: begin
                    pc    <= pc + 1'b1;
                    state <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // ALU issue: alu_valid, alu_op and operands stay stable in EXEC until the
    // cycle where alu_valid && alu_ready, which is the single accepting cycle.
    assign alu_valid  = (state == S_EXEC) && is_alu;
    assign alu_op     = alu_valid ? alu_op_of(opcode) : 4'd0;
    assign alu_a      = alu_valid ? rf_rdata_a : '0;
    assign alu_b      = alu_valid ? rf_rdata_b : '0;

    assign rf_raddr_a = REG_AW'(is_alu ? rsrc2 : rsrc1);
    assign rf_raddr_b = REG_AW'(rsrc1);
    assign rf_we      = (state == S_WB2) || (state == S_WB1);
    assign rf_waddr   = REG_AW'((state == S_WB1) ? rdst1 : rdst2);
    assign rf_wdata   = (state == S_WB1) ? aux_q : res_q;

    assign dmem_we    = (state == S_EXEC) && (opcode == OP_ST);
    assign dmem_addr  = DMEM_AW'((opcode == OP_ST) ? st_addr : addr8);
    assign dmem_wdata = dmem_we ? rf_rdata_b : '0;

    assign imem_addr  = pc;
    assign busy       = (state != S_IDLE) && (state != S_HALT);
    assign state_dbg  = state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: memory, register-file and ALU models,
// a write-back scoreboard and hand-computed expectations per program.
module tb_instr_sequencer;
    import proc_defs::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [4:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic        rf_we, alu_valid, alu_ready, alu_done;
    logic [3:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_result, alu_aux;
    logic [7:0]  dmem_addr;
    logic        dmem_we;
    logic [15:0] dmem_wdata, dmem_rdata;
    logic [7:0]  pc;
    logic        busy, halted, illegal;
    state_t      state_dbg;

    // second instance with a 2-bit PC for the wrap test
    logic        start2;
    logic [1:0]  imem_addr2, pc2;
    logic [31:0] imem_rdata2;
    logic [4:0]  rf_raddr_a2, rf_raddr_b2, rf_waddr2;
    logic [15:0] rf_wdata2, alu_a2, alu_b2, dmem_wdata2;
    logic        rf_we2, alu_valid2, dmem_we2, busy2, halted2, illegal2;
    logic [3:0]  alu_op2;
    logic [7:0]  dmem_addr2;
    state_t      state_dbg2;
    logic [15:0] zero16 = 16'h0;
    logic        zero1 = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] imem [256];
    logic [31:0] imem2 [4];
    logic [15:0] regs [32];
    logic [15:0] dmem [256];

    int          ready_dly, done_dly, valid_cnt, post_cnt, cyc;
    logic [15:0] alu_res_v, alu_aux_v, exp_a, exp_b;

    logic [20:0] exp_q[$];
    int          wcyc_q[$];
    logic [7:0]  fetch_q[$];
    logic [1:0]  fetch2_q[$];
    int          we_cnt, dwe_cnt, hs_cnt, overlap, rf_extra, dwe_cyc;
    logic [7:0]  dwe_addr;
    logic [15:0] dwe_data;

    always #5 clk = ~clk;

    instr_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done),
        .alu_result(alu_result), .alu_aux(alu_aux),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .pc(pc), .busy(busy), .halted(halted),
        .illegal(illegal), .state_dbg(state_dbg)
    );

    instr_sequencer #(.PC_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .rf_raddr_a(rf_raddr_a2), .rf_raddr_b(rf_raddr_b2),
        .rf_rdata_a(zero16), .rf_rdata_b(zero16),
        .rf_we(rf_we2), .rf_waddr(rf_waddr2), .rf_wdata(rf_wdata2),
        .alu_valid(alu_valid2), .alu_ready(zero1), .alu_op(alu_op2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_done(zero1),
        .alu_result(zero16), .alu_aux(zero16),
        .dmem_addr(dmem_addr2), .dmem_we(dmem_we2), .dmem_wdata(dmem_wdata2),
        .dmem_rdata(zero16), .pc(pc2), .busy(busy2), .halted(halted2),
        .illegal(illegal2), .state_dbg(state_dbg2)
    );

    // ---------------- models ----------------
    always @(posedge clk) imem_rdata  <= imem[imem_addr];
    always @(posedge clk) imem_rdata2 <= imem2[imem_addr2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) for (int i = 0; i < 32; i++) regs[i] <= '0;
        else if (rf_we) regs[rf_waddr] <= rf_wdata;
    end
    assign rf_rdata_a = regs[rf_raddr_a];
    assign rf_rdata_b = regs[rf_raddr_b];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) dmem[i] <= '0;
            dmem_rdata <= '0;
        end else begin
            if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
            dmem_rdata <= dmem[dmem_addr];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_cnt <= 0;
            post_cnt  <= 0;
        end else begin
            valid_cnt <= alu_valid ? valid_cnt + 1 : 0;
            if (alu_valid && alu_ready) post_cnt <= 1;
            else if (alu_done)          post_cnt <= 0;
            else if (post_cnt != 0)     post_cnt <= post_cnt + 1;
        end
    end
    assign alu_ready  = alu_valid && (valid_cnt >= ready_dly);
    assign alu_done   = (post_cnt != 0) && (post_cnt == done_dly);
    assign alu_result = alu_res_v;
    assign alu_aux    = alu_aux_v;

    always @(posedge clk) cyc <= start ? 1 : cyc + 1;

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            we_cnt = 0; dwe_cnt = 0; hs_cnt = 0; overlap = 0; rf_extra = 0;
            wcyc_q.delete(); fetch_q.delete(); fetch2_q.delete();
        end else begin
            if (rf_we) begin
                we_cnt++;
                wcyc_q.push_back(cyc);
                if (exp_q.size() == 0) rf_extra++;
                else check_val("rf_write", 32'({rf_waddr, rf_wdata}), 32'(exp_q.pop_front()));
            end
            if (dmem_we) begin
                dwe_cnt++;
                dwe_cyc  = cyc;
                dwe_addr = dmem_addr;
                dwe_data = dmem_wdata;
            end
            if (rf_we && dmem_we) overlap++;
            if (alu_valid) begin
                check_val("alu_op", 32'(alu_op), 32'(ALU_ADD));
                check_val("alu_a", 32'(alu_a), 32'(exp_a));
                check_val("alu_b", 32'(alu_b), 32'(exp_b));
                if (alu_ready) hs_cnt++;
            end
            if (state_dbg == S_FETCH)  fetch_q.push_back(imem_addr);
            if (state_dbg2 == S_FETCH) fetch2_q.push_back(imem_addr2);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 32'hFC00_0000;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input int max_cyc);
        for (int i = 0; i < max_cyc && !halted; i++) @(negedge clk);
        check_val("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic push_alu_prog();
        clear_imem();
        imem[0] = 32'h0020_0002;   // LDI R1, 2
        imem[1] = 32'h0040_0003;   // LDI R2, 3
        imem[2] = 32'h3464_0022;   // ADD R3/R4 <- R1, R2
        exp_q.push_back({5'd1, 16'h0002});
        exp_q.push_back({5'd2, 16'h0003});
        exp_q.push_back({5'd3, 16'h0005});
        exp_q.push_back({5'd4, 16'h0001});
    endtask

    logic [1:0] wrap_exp [5];

    initial begin
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        ready_dly = 2; done_dly = 3;
        alu_res_v = 16'h0005; alu_aux_v = 16'h0001;
        exp_a = 16'h0002; exp_b = 16'h0003;
        wrap_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        clear_imem();
        imem2[0] = 32'h0020_0001; imem2[1] = 32'h0040_0002;
        imem2[2] = 32'h0060_0003; imem2[3] = 32'h0080_0004;
        repeat (3) @(negedge clk);

        // reset state
        check_val("rst_state", 32'(state_dbg), 32'(S_IDLE));
        check_val("rst_pc", 32'(pc), 32'd0);
        check_val("rst_status", {29'd0, busy, halted, illegal}, 32'd0);
        check_val("rst_strobes", {29'd0, rf_we, dmem_we, alu_valid}, 32'd0);
        check_val("rst_addr", {imem_addr, dmem_addr, 11'd0, rf_waddr}, 32'd0);
        check_val("rst_wdata", {rf_wdata, dmem_wdata}, 32'd0);

        // LDI R1, 0x1234 then HALT
        clear_imem();
        imem[0] = 32'h0020_1234;
        do_reset();
        exp_q.push_back({5'd1, 16'h1234});
        pulse_start();
        wait_halt(30);
        check_val("ldi_done", 32'(exp_q.size()), 32'd0);
        check_val("ldi_wb_cycle", 32'(wcyc_q[0]), 32'd4);
        check_val("ldi_pc", 32'(pc), 32'd1);
        check_val("ldi_illegal", 32'(illegal), 32'd0);
        check_val("ldi_busy", 32'(busy), 32'd0);

        // ALU ADD with ready wait 2 and done 3 cycles after handshake
        push_alu_prog();
        do_reset();
        pulse_start();
        wait_halt(60);
        check_val("alu_done_q", 32'(exp_q.size()), 32'd0);
        check_val("alu_issues", 32'(hs_cnt), 32'd1);
        check_val("alu_writes", 32'(we_cnt), 32'd4);
        check_val("alu_wb2_cycle", 32'(wcyc_q[2]), 32'd17);
        check_val("alu_wb1_cycle", 32'(wcyc_q[3]), 32'd18);
        check_val("alu_pc", 32'(pc), 32'd3);

        // ST then LD then MOV
        clear_imem();
        imem[0] = 32'h00E0_BEEF;   // LDI R7, 0xBEEF
        imem[1] = 32'h0E94_0007;   // ST [0xA5] <- R7
        imem[2] = 32'h0840_00A5;   // LD R2 <- [0xA5]
        imem[3] = 32'h04A0_0002;   // MOV R5 <- R2
        do_reset();
        exp_q.push_back({5'd7, 16'hBEEF});
        exp_q.push_back({5'd2, 16'hBEEF});
        exp_q.push_back({5'd5, 16'hBEEF});
        pulse_start();
        wait_halt(60);
        check_val("mem_done_q", 32'(exp_q.size()), 32'd0);
        check_val("st_pulses", 32'(dwe_cnt), 32'd1);
        check_val("st_addr", 32'(dwe_addr), 32'h00A5);
        check_val("st_data", 32'(dwe_data), 32'hBEEF);
        check_val("st_cycle", 32'(dwe_cyc), 32'd7);
        check_val("ld_wb_cycle", 32'(wcyc_q[1]), 32'd12);
        check_val("we_overlap", 32'(overlap), 32'd0);
        check_val("mem_pc", 32'(pc), 32'd4);

        // illegal opcode 010010
        clear_imem();
        imem[0] = 32'h4800_0000;
        do_reset();
        pulse_start();
        wait_halt(30);
        check_val("ill_flag", 32'(illegal), 32'd1);
        check_val("ill_rf_we", 32'(we_cnt), 32'd0);
        check_val("ill_dmem_we", 32'(dwe_cnt), 32'd0);
        pulse_start();
        repeat (5) @(negedge clk);
        check_val("ill_state", 32'(state_dbg), 32'(S_HALT));
        check_val("ill_busy", 32'(busy), 32'd0);
        check_val("ill_fetches", 32'(fetch_q.size()), 32'd1);
        check_val("ill_pc", 32'(pc), 32'd0);

        // 2-bit PC wraps 3 -> 0
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int i = 0; i < 40 && fetch2_q.size() < 5; i++) @(negedge clk);
        check_val("wrap_fetch_cnt", 32'(fetch2_q.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) check_val("wrap_fetch_addr", 32'(fetch2_q[i]), 32'(wrap_exp[i]));

        // reset while waiting for alu_done, then re-run from address 0
        push_alu_prog();
        done_dly = 50;
        do_reset();
        pulse_start();
        for (int i = 0; i < 40 && state_dbg != S_ALU_WAIT; i++) @(negedge clk);
        check_val("reach_alu_wait", 32'(state_dbg), 32'(S_ALU_WAIT));
        check_val("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_state", 32'(state_dbg), 32'(S_IDLE));
        check_val("arst_strobes", {29'd0, busy, alu_valid, rf_we}, 32'd0);
        check_val("arst_pc", 32'(pc), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_dly = 3;
        exp_q.delete();
        push_alu_prog();
        @(negedge clk);
        pulse_start();
        wait_halt(60);
        check_val("rerun_done_q", 32'(exp_q.size()), 32'd0);
        check_val("rerun_first_fetch", 32'(fetch_q[0]), 32'd0);
        check_val("rerun_pc", 32'(pc), 32'd3);
        check_val("rerun_issues", 32'(hs_cnt), 32'd1);
        check_val("rf_unexpected", 32'(rf_extra), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control FSM for the 16-bit Harvard processor core. Fetches 32-bit instruction words from instruction memory and splits them into opcode and register/immediate fields. Sequences the external register file, the shared ALU (logic, barrel shifters, recursive adder and subtractor) and data memory through fetch, decode, execute and write-back. Sits between the program counter / instruction memory and the datapath and is the only block that drives register-file write and ALU issue.

## Interface
Parameters:
- PC_W, 8, instruction address width; PC wraps modulo 2^PC_W
- DATA_W, 16, datapath width
- REG_AW, 5, register address width (32 registers)
- DMEM_AW, 8, data memory address width

Ports (one clock; reset asynchronous, active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; leaves IDLE, PC=0
- imem_addr  out  PC_W  instruction fetch address (sync memory, 1-cycle read)
- imem_rdata  in  32  instruction word
- rf_raddr_a / rf_raddr_b  out  REG_AW  register read addresses (combinational read)
- rf_rdata_a / rf_rdata_b  in  DATA_W  read data
- rf_we  out  1; rf_waddr  out  REG_AW; rf_wdata  out  DATA_W  single write port
- alu_valid  out  1; alu_ready  in  1  issue handshake
- alu_op  out  4  opcode − 4; alu_a / alu_b  out  DATA_W  operands
- alu_done  in  1  one-cycle completion pulse; alu_result / alu_aux  in  DATA_W
- dmem_addr  out  DMEM_AW; dmem_we  out  1; dmem_wdata  out  DATA_W; dmem_rdata  in  DATA_W (1-cycle read)
- pc  out  PC_W; busy, halted, illegal  out  1

## Operation
Instruction fields: opcode IR[31:26], Rdst2 IR[25:21], Rdst1 IR[20:16].
- 000000 LDI: Rdst2 ← IR[15:0]
- 000001 MOV: Rdst2 ← R[IR[4:0]]
- 000010 LD: Rdst2 ← DMEM[IR[7:0]]
- 000011 ST: DMEM[IR[25:18]] ← R[IR[4:0]]
- 000100–010001 ALU: alu_a = R[IR[9:5]], alu_b = R[IR[4:0]], alu_op = opcode−4; Rdst2 ← alu_result, then Rdst1 ← alu_aux
- 111111 HALT; any other opcode is illegal.

Read-port mux: rf_raddr_a = IR[9:5] for ALU ops, otherwise IR[4:0]; rf_raddr_b = IR[4:0].

States:
- IDLE: start → FETCH
- FETCH: drive imem_addr=pc → DECODE
- DECODE: IR ← imem_rdata → EXEC
- EXEC: LDI/MOV/LD/ST/ALU dispatch as listed; HALT or illegal → HALT
- MEM_RD
- ALU_WAIT
- WB2, then WB1
- HALT: absorbing until reset

Transitions:
- EXEC, LDI/MOV: → WB2
- EXEC, LD: drive dmem_addr → MEM_RD → WB2 (data from dmem_rdata)
- EXEC, ST: dmem_we=1 for exactly one cycle → FETCH
- EXEC, ALU: hold alu_valid, alu_op and operands stable until alu_ready=1. Handshake completes in the cycle both are high → ALU_WAIT. alu_done in ALU_WAIT captures result and aux → WB2 → WB1 → FETCH.
- WB2: rf_we=1, waddr=Rdst2; → FETCH for non-ALU ops, → WB1 for ALU ops
- WB1: rf_we=1, waddr=Rdst1 → FETCH

PC and status:
- pc increments on every entry to FETCH except the first after start; 2^PC_W−1 wraps to 0.
- HALT opcode: halted=1. Illegal opcode: illegal=1 and halted=1.

## Timing
- Reset: state IDLE; pc=0, IR=0. All strobes (rf_we, dmem_we, alu_valid) are 0. busy, halted and illegal are 0. All address and data outputs are 0.
- Instruction latency in cycles: LDI/MOV 4, LD 5, ST 3, HALT 3. ALU takes 3 + ready wait + (cycles until alu_done) + 2.
- busy=1 in every state except IDLE and HALT; start is ignored when not in IDLE.
- alu_done outside ALU_WAIT is ignored. alu_done in the same cycle as the accepting handshake is ignored; alu_done is counted from the cycle after the handshake.
- When Rdst1 = Rdst2 on an ALU op, both writes occur and the WB1 value (aux) remains.
- rst_n low mid-instruction asynchronously returns to IDLE. Any pending register-file, data-memory or ALU transaction is abandoned; the strobes drop immediately.
- rf_we and dmem_we are never high in the same cycle. At most one rf_we cycle occurs per write-back state.

## Structure
- Shared package proc_defs: opcode localparams, state encoding, ALU op codes (opcode−4), field bit positions. The ALU and test bench reuse it.
- One sub-module instr_fields: combinational IR → opcode, Rdst2, Rdst1, register sources, imm16, addr8 fields and is_alu/is_illegal class bits. The FSM, PC and IR registers stay in instr_sequencer.

## Test plan
- LDI: word 0x0020_1234 at pc 0, then HALT → rf write R1=0x1234 in cycle 4; halted=1 afterward; pc=1.
- ALU ADD (opcode 001101), Rdst2=3, Rdst1=4, Rsrc2=1, Rsrc1=2. ALU model asserts ready after 2 cycles and done 3 cycles later with result 0x0005, aux 0x0001 → exactly one alu_op=9 issue with operands held stable. Then R3=5 and R4=1 are written on consecutive cycles.
- ST then LD: ST to address 0xA5 from R7=0xBEEF, then LD R2 from 0xA5 → one dmem_we pulse at addr 0xA5, data 0xBEEF; R2=0xBEEF.
- Opcode 010010 → illegal=1, halted=1, no rf_we or dmem_we; start is ignored afterward.
- PC_W=2, four LDI words → fetch addresses 0, 1, 2, 3, 0.
- rst_n asserted while in ALU_WAIT → alu_valid, rf_we and busy drop at once; IDLE, pc=0; a later start re-executes from address 0.
